// File: rtl/apb_uart_rx_fifo_slave.sv
// ============================================================================
// apb_uart_rx_fifo_slave: APB slave for the UART receiver with an RX FIFO.
// Optional macro APB_UART_IRQ_EN adds the INT_EN register and the irq output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module apb_uart_rx_fifo_slave #(
   parameter int          FIFO_DEPTH       = 4,
   parameter logic [13:0] RESET_BIT_PERIOD = 14'd10,
   parameter logic [3:0]  RESET_DATA_SIZE  = 4'd8
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        psel,
   input  logic [2:0]  paddr,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [7:0]  pwdata,
   output logic [7:0]  prdata,
   output logic        pslverr,
   input  logic [7:0]  rx_data,
   input  logic        data_ready,
   input  logic        overrun_error,
   input  logic        framing_error,
   output logic        data_read,
   output logic [3:0]  data_size,
   output logic [13:0] bit_period,
   output logic        irq
);

   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(FIFO_DEPTH);

   localparam logic [2:0] c_ADDR_STATUS  = 3'd0;
   localparam logic [2:0] c_ADDR_ERROR   = 3'd1;
   localparam logic [2:0] c_ADDR_BIT_CR0 = 3'd2;
   localparam logic [2:0] c_ADDR_BIT_CR1 = 3'd3;
   localparam logic [2:0] c_ADDR_DATA_CR = 3'd4;
   localparam logic [2:0] c_ADDR_LEVEL   = 3'd5;
   localparam logic [2:0] c_ADDR_RX_DATA = 3'd6;
   localparam logic [2:0] c_ADDR_INT_EN  = 3'd7;

`ifdef APB_UART_IRQ_EN
   localparam logic c_IRQ_PRESENT = 1'b1;
`else
   localparam logic c_IRQ_PRESENT = 1'b0;
`endif

   logic [7:0]         r_fifo [FIFO_DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic [1:0]         r_err;
   logic [13:0]        r_bit_period;
   logic [3:0]         r_data_size;
   logic               r_data_ready_q;
   logic               r_data_read;

   logic               w_access;
   logic               w_wr;
   logic               w_rd;
   logic               w_empty;
   logic               w_full;
   logic               w_capture;
   logic               w_push;
   logic               w_pop;
   logic               w_err_clr;
   logic [1:0]         w_err_set;
   logic               w_ds_legal;
   logic               w_wr_err;
   logic               w_wr_ok;
   logic [7:0]         w_mask;
   logic [7:0]         w_rdata;
   logic [1:0]         w_int_en;

   assign w_access   = psel & penable;
   assign w_wr       = w_access & pwrite;
   assign w_rd       = w_access & ~pwrite;
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == c_FULL_CNT);
   assign w_capture  = data_ready & ~r_data_ready_q;
   assign w_push     = w_capture & ~w_full;
   assign w_pop      = w_rd & (paddr == c_ADDR_RX_DATA) & ~w_empty;
   assign w_err_clr  = w_rd & (paddr == c_ADDR_ERROR);
   // A byte arriving at a full FIFO is reported as an overrun.
   assign w_err_set  = {overrun_error | (w_capture & w_full), framing_error};
   assign w_ds_legal = (pwdata[3:0] >= 4'd5) && (pwdata[3:0] <= 4'd8);

   always_comb begin
      w_wr_err = 1'b0;
      case (paddr)
         c_ADDR_STATUS,
         c_ADDR_ERROR,
         c_ADDR_LEVEL,
         c_ADDR_RX_DATA: w_wr_err = 1'b1;
         c_ADDR_DATA_CR: w_wr_err = ~w_ds_legal;
         c_ADDR_INT_EN:  w_wr_err = ~c_IRQ_PRESENT;
         default:        w_wr_err = 1'b0;
      endcase
   end

   assign w_wr_ok = w_wr & ~w_wr_err;
   assign pslverr = psel & pwrite & w_wr_err;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_data_ready_q <= 1'b0;
         r_data_read    <= 1'b0;
      end else begin
         r_data_ready_q <= data_ready;
         r_data_read    <= w_capture;
      end
   end

   // Storage needs no reset: the count and pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= rx_data;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_bit_period <= RESET_BIT_PERIOD;
         r_data_size  <= RESET_DATA_SIZE;
      end else if (w_wr_ok) begin
         case (paddr)
            c_ADDR_BIT_CR0: r_bit_period[7:0]  <= pwdata;
            c_ADDR_BIT_CR1: r_bit_period[13:8] <= pwdata[5:0];
            c_ADDR_DATA_CR: r_data_size        <= pwdata[3:0];
            default: ;
         endcase
      end
   end

   // New errors win over the read-clear so none is lost.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_err <= 2'b00;
      end else begin
         r_err <= (w_err_clr ? 2'b00 : r_err) | w_err_set;
      end
   end

   always_comb begin
      w_mask = 8'h00;
      for (int i = 0; i < 8; i++) begin
         w_mask[i] = (i < int'(r_data_size));
      end
   end

   always_comb begin
      w_rdata = 8'h00;
      if (psel && !pwrite) begin
         case (paddr)
            c_ADDR_STATUS:  w_rdata = {6'b0, w_full, ~w_empty};
            c_ADDR_ERROR:   w_rdata = {6'b0, r_err};
            c_ADDR_BIT_CR0: w_rdata = r_bit_period[7:0];
            c_ADDR_BIT_CR1: w_rdata = {2'b00, r_bit_period[13:8]};
            c_ADDR_DATA_CR: w_rdata = {4'b0000, r_data_size};
            c_ADDR_LEVEL:   w_rdata = 8'(r_count);
            c_ADDR_RX_DATA: w_rdata = w_empty ? 8'h00 : (r_fifo[r_rd_ptr] & w_mask);
            c_ADDR_INT_EN:  w_rdata = {6'b0, w_int_en};
            default:        w_rdata = 8'h00;
         endcase
      end
   end

   assign prdata     = w_rdata;
   assign data_read  = r_data_read;
   assign bit_period = r_bit_period;
   assign data_size  = r_data_size;

`ifdef APB_UART_IRQ_EN
   logic [1:0] r_int_en;
   logic       r_irq;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_int_en <= 2'b00;
         r_irq    <= 1'b0;
      end else begin
         if (w_wr_ok && (paddr == c_ADDR_INT_EN)) begin
            r_int_en <= pwdata[1:0];
         end
         r_irq <= (r_int_en[0] & ~w_empty) | (r_int_en[1] & (|r_err));
      end
   end

   assign w_int_en = r_int_en;
   assign irq      = r_irq;
`else
   assign w_int_en = 2'b00;
   assign irq      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_apb_uart_rx_fifo_slave.sv
// Self-checking bench for apb_uart_rx_fifo_slave: register table, directed
// corner sequences and a randomized run against a queue-based model.
`default_nettype none

module tb_apb_uart_rx_fifo_slave;

   localparam int DEPTH = 4;
`ifdef APB_UART_IRQ_EN
   localparam bit IRQ_BUILD = 1'b1;
`else
   localparam bit IRQ_BUILD = 1'b0;
`endif

   logic        tb_clk = 1'b0;
   logic        n_rst;
   logic        psel;
   logic [2:0]  paddr;
   logic        penable;
   logic        pwrite;
   logic [7:0]  pwdata;
   logic [7:0]  prdata;
   logic        pslverr;
   logic [7:0]  rx_data;
   logic        data_ready;
   logic        overrun_error;
   logic        framing_error;
   logic        data_read;
   logic [3:0]  data_size;
   logic [13:0] bit_period;
   logic        irq;

   always #5 tb_clk = ~tb_clk;

   apb_uart_rx_fifo_slave #(.FIFO_DEPTH(DEPTH)) dut (
      .clk           (tb_clk),
      .n_rst         (n_rst),
      .psel          (psel),
      .paddr         (paddr),
      .penable       (penable),
      .pwrite        (pwrite),
      .pwdata        (pwdata),
      .prdata        (prdata),
      .pslverr       (pslverr),
      .rx_data       (rx_data),
      .data_ready    (data_ready),
      .overrun_error (overrun_error),
      .framing_error (framing_error),
      .data_read     (data_read),
      .data_size     (data_size),
      .bit_period    (bit_period),
      .irq           (irq)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [7:0]  m_q[$];
   logic [1:0]  m_err;
   logic [13:0] m_bp;
   logic [3:0]  m_ds;
   logic [1:0]  m_ie;

   typedef struct {
      logic       wr;
      logic [2:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
      logic       exp_err;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] m_masked(input logic [7:0] b);
      int m;
      m = (1 << m_ds) - 1;
      return b & 8'(m);
   endfunction

   function automatic logic [7:0] m_rx_pop();
      logic [7:0] b;
      if (m_q.size() == 0) return 8'h00;
      b = m_q.pop_front();
      return m_masked(b);
   endfunction

   function automatic void m_push(input logic [7:0] b);
      if (m_q.size() < DEPTH) m_q.push_back(b);
      else m_err[1] = 1'b1;
   endfunction

   function automatic logic m_irq();
      if (!IRQ_BUILD) return 1'b0;
      return (m_ie[0] && m_q.size() > 0) || (m_ie[1] && m_err != 2'b00);
   endfunction

   function automatic logic m_wr_err(input logic [2:0] a, input logic [7:0] d);
      case (a)
         3'd0, 3'd1, 3'd5, 3'd6: return 1'b1;
         3'd4:    return !(d[3:0] >= 4'd5 && d[3:0] <= 4'd8);
         3'd7:    return !IRQ_BUILD;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [7:0] m_read_value(input logic [2:0] a);
      case (a)
         3'd0:    return {6'b0, m_q.size() == DEPTH, m_q.size() != 0};
         3'd1:    return {6'b0, m_err};
         3'd2:    return m_bp[7:0];
         3'd3:    return {2'b00, m_bp[13:8]};
         3'd4:    return {4'b0, m_ds};
         3'd5:    return 8'(m_q.size());
         3'd6:    return (m_q.size() == 0) ? 8'h00 : m_masked(m_q[0]);
         default: return IRQ_BUILD ? {6'b0, m_ie} : 8'h00;
      endcase
   endfunction

   task automatic apb_write(input logic [2:0] a, input logic [7:0] d, output logic err);
      @(posedge tb_clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      @(posedge tb_clk); #1;
      penable = 1'b1;
      #1 err = pslverr;
      @(posedge tb_clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [2:0] a, output logic [7:0] d, output logic err);
      @(posedge tb_clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      @(posedge tb_clk); #1;
      penable = 1'b1;
      #1 d = prdata; err = pslverr;
      @(posedge tb_clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   // Read with an explicit expected value; keeps the model in step.
   task automatic rd_exp(input string name, input logic [2:0] a, input logic [7:0] exp);
      logic [7:0] d;
      logic       e;
      apb_read(a, d, e);
      chk(name, d, exp);
      chk({name, "_slverr"}, e, 1'b0);
      if (a == 3'd6 && m_q.size() != 0) void'(m_q.pop_front());
      if (a == 3'd1) m_err = 2'b00;
   endtask

   task automatic wr_exp(input string name, input logic [2:0] a, input logic [7:0] d,
                         input logic exp_err);
      logic e;
      apb_write(a, d, e);
      chk(name, e, exp_err);
      if (!exp_err) begin
         case (a)
            3'd2: m_bp[7:0]  = d;
            3'd3: m_bp[13:8] = d[5:0];
            3'd4: m_ds       = d[3:0];
            3'd7: m_ie       = d[1:0];
            default: ;
         endcase
      end
   endtask

   task automatic uart_push(input logic [7:0] b);
      @(posedge tb_clk); #1;
      rx_data = b; data_ready = 1'b1;
      chk("data_read_pre", data_read, 1'b0);
      @(posedge tb_clk); #1;
      chk("data_read_pulse", data_read, 1'b1);
      @(posedge tb_clk); #1;
      chk("data_read_end", data_read, 1'b0);
      data_ready = 1'b0; rx_data = 8'($urandom);
      m_push(b);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] d;
      logic       e;
      int         op;
      logic [2:0] a;

      // Reset with all UART inputs held high
      n_rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 3'd0; pwdata = 8'h00; rx_data = 8'hFF;
      data_ready = 1'b1; overrun_error = 1'b1; framing_error = 1'b1;
      m_err = 2'b00; m_bp = 14'd10; m_ds = 4'd8; m_ie = 2'b00;
      repeat (3) @(posedge tb_clk);
      #1;
      chk("rst_data_read", data_read, 1'b0);
      chk("rst_bit_period", bit_period, 14'd10);
      chk("rst_data_size", data_size, 4'd8);
      chk("rst_irq", irq, 1'b0);
      psel = 1'b1; paddr = 3'd0;
      #1 chk("rst_status", prdata, 8'h00);
      paddr = 3'd5;
      #1 chk("rst_level", prdata, 8'h00);
      paddr = 3'd1;
      #1 chk("rst_error", prdata, 8'h00);
      psel = 1'b0;
      data_ready = 1'b0; overrun_error = 1'b0; framing_error = 1'b0;
      @(posedge tb_clk); #1;
      n_rst = 1'b1;

      // Register access table
      vecs.push_back('{1'b1, 3'd2, 8'hE8, 8'h00, 1'b0});
      vecs.push_back('{1'b1, 3'd3, 8'h03, 8'h00, 1'b0});
      vecs.push_back('{1'b0, 3'd2, 8'h00, 8'hE8, 1'b0});
      vecs.push_back('{1'b0, 3'd3, 8'h00, 8'h03, 1'b0});
      vecs.push_back('{1'b1, 3'd4, 8'h09, 8'h00, 1'b1});
      vecs.push_back('{1'b0, 3'd4, 8'h00, 8'h08, 1'b0});
      vecs.push_back('{1'b1, 3'd4, 8'h04, 8'h00, 1'b1});
      vecs.push_back('{1'b1, 3'd0, 8'h01, 8'h00, 1'b1});
      vecs.push_back('{1'b1, 3'd1, 8'h03, 8'h00, 1'b1});
      vecs.push_back('{1'b1, 3'd5, 8'h02, 8'h00, 1'b1});
      vecs.push_back('{1'b1, 3'd6, 8'h55, 8'h00, 1'b1});
      vecs.push_back('{1'b1, 3'd3, 8'hC3, 8'h00, 1'b0});
      vecs.push_back('{1'b0, 3'd3, 8'h00, 8'h03, 1'b0});
      vecs.push_back('{1'b1, 3'd7, 8'h00, 8'h00, !IRQ_BUILD});
      vecs.push_back('{1'b0, 3'd7, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{1'b0, 3'd0, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{1'b0, 3'd5, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{1'b0, 3'd1, 8'h00, 8'h00, 1'b0});
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].wr) begin
            apb_write(vecs[i].addr, vecs[i].wdata, e);
            chk($sformatf("vec%0d_slverr", i), e, vecs[i].exp_err);
         end else begin
            apb_read(vecs[i].addr, d, e);
            chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_slverr", i), e, 1'b0);
         end
      end
      m_bp = 14'd1000;
      chk("cfg_bit_period", bit_period, 14'd1000);
      chk("cfg_data_size", data_size, 4'd8);

      // Three pushes, masked reads with data_size 5
      uart_push(8'h55);
      uart_push(8'hAA);
      uart_push(8'h0F);
      rd_exp("level_3", 3'd5, 8'd3);
      wr_exp("ds5_write", 3'd4, 8'h05, 1'b0);
      chk("ds5_port", data_size, 4'd5);
      rd_exp("rx_mask0", 3'd6, 8'h15);
      rd_exp("rx_mask1", 3'd6, 8'h0A);
      rd_exp("rx_mask2", 3'd6, 8'h0F);
      rd_exp("level_0", 3'd5, 8'd0);
      rd_exp("status_0", 3'd0, 8'h00);

      // Overflow at full FIFO
      wr_exp("ds8_write", 3'd4, 8'h08, 1'b0);
      uart_push(8'h11);
      uart_push(8'h22);
      uart_push(8'h33);
      uart_push(8'h44);
      uart_push(8'h77);
      rd_exp("full_level", 3'd5, 8'd4);
      rd_exp("full_status", 3'd0, 8'h03);
      rd_exp("ovr_error", 3'd1, 8'h02);
      rd_exp("ovr_cleared", 3'd1, 8'h00);
      rd_exp("full_rx0", 3'd6, 8'h11);
      rd_exp("full_rx1", 3'd6, 8'h22);
      rd_exp("full_rx2", 3'd6, 8'h33);
      rd_exp("full_rx3", 3'd6, 8'h44);
      rd_exp("empty_rx", 3'd6, 8'h00);
      rd_exp("empty_level", 3'd5, 8'd0);

      // Push edge coincides with RX_DATA pop at level 2
      uart_push(8'hA1);
      uart_push(8'hB2);
      @(posedge tb_clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 3'd6;
      @(posedge tb_clk); #1;
      penable = 1'b1; rx_data = 8'hC3; data_ready = 1'b1;
      #1 chk("sim_pop_data", prdata, 8'hA1);
      @(posedge tb_clk); #1;
      psel = 1'b0; penable = 1'b0;
      chk("sim_data_read", data_read, 1'b1);
      @(posedge tb_clk); #1;
      data_ready = 1'b0;
      void'(m_q.pop_front());
      m_push(8'hC3);
      rd_exp("sim_level", 3'd5, 8'd2);
      rd_exp("sim_rx0", 3'd6, 8'hB2);
      rd_exp("sim_rx1", 3'd6, 8'hC3);

      // Framing error coincides with ERROR read clear
      @(posedge tb_clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 3'd1;
      @(posedge tb_clk); #1;
      penable = 1'b1; framing_error = 1'b1;
      #1 chk("fe_clear_read", prdata, 8'h00);
      @(posedge tb_clk); #1;
      psel = 1'b0; penable = 1'b0; framing_error = 1'b0;
      m_err = 2'b01;
      rd_exp("fe_kept", 3'd1, 8'h01);
      rd_exp("fe_gone", 3'd1, 8'h00);

`ifdef APB_UART_IRQ_EN
      // Data-available interrupt follows push and pop by one cycle
      wr_exp("ie_write", 3'd7, 8'h01, 1'b0);
      @(posedge tb_clk); #1;
      rx_data = 8'h5A; data_ready = 1'b1;
      @(posedge tb_clk); #1;
      chk("irq_low_at_push", irq, 1'b0);
      @(posedge tb_clk); #1;
      chk("irq_after_push", irq, 1'b1);
      data_ready = 1'b0;
      m_push(8'h5A);
      rd_exp("irq_pop", 3'd6, 8'h5A);
      chk("irq_at_pop", irq, 1'b1);
      @(posedge tb_clk); #1;
      chk("irq_after_pop", irq, 1'b0);
`endif

      // Randomized run against the model
      for (int it = 0; it < 300; it++) begin
         op = $urandom_range(0, 9);
         case (op)
            0, 1, 2: uart_push(8'($urandom));
            3, 4: begin
               d = m_read_value(3'd6);
               rd_exp("rnd_rx", 3'd6, d);
            end
            5: begin
               a = 3'($urandom_range(0, 7));
               d = m_read_value(a);
               rd_exp($sformatf("rnd_rd%0d", a), a, d);
            end
            6: begin
               a = 3'($urandom_range(0, 7));
               d = 8'($urandom);
               wr_exp($sformatf("rnd_wr%0d", a), a, d, m_wr_err(a, d));
            end
            7: begin
               @(posedge tb_clk); #1;
               if ($urandom_range(0, 1) == 0) begin
                  framing_error = 1'b1; m_err[0] = 1'b1;
               end else begin
                  overrun_error = 1'b1; m_err[1] = 1'b1;
               end
               @(posedge tb_clk); #1;
               framing_error = 1'b0; overrun_error = 1'b0;
            end
            8: begin
               d = m_read_value(3'd1);
               rd_exp("rnd_err", 3'd1, d);
            end
            default: begin
               d = 8'($urandom_range(4, 9));
               wr_exp("rnd_ds", 3'd4, d, m_wr_err(3'd4, d));
            end
         endcase
         @(posedge tb_clk); #1;
         chk("rnd_irq", irq, m_irq());
         chk("rnd_bit_period", bit_period, m_bp);
         chk("rnd_data_size", data_size, m_ds);
      end
      rd_exp("final_level", 3'd5, 8'(m_q.size()));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
